// File: rtl/rr_mux_reg.sv
// Round-robin N:1 valid/ready mux with a single registered output stage.
// Optional packet locking (in_last) is enabled by defining RR_MUX_REG_LOCK_EN.
module rr_mux_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
`ifdef RR_MUX_REG_LOCK_EN
  input  logic [NUM_IN-1:0]       in_last,
`endif
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_src_q, out_src_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  last_grant_q, last_grant_d;
  logic              lock_q, lock_d;

  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  gnt_idx;
  logic [SEL_W-1:0]  cand;
  logic              found;
  logic              load;
  logic              xfer;

  // Arbitration: scan from last_grant+1 modulo NUM_IN; a held lock pins the grant.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    if (lock_q) begin
      if (in_valid[last_grant_q]) begin
        grant[last_grant_q] = 1'b1;
        gnt_idx             = last_grant_q;
      end
    end else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        cand = SEL_W'((int'(last_grant_q) + k) % NUM_IN);
        if (!found && in_valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          gnt_idx     = cand;
        end
      end
    end
  end

  // Reset suppresses in_ready so no producer believes a word was taken.
  always_comb begin
    load         = (~out_valid_q | out_ready) & ~reset;
    xfer         = load & (|grant);
    in_ready     = load ? grant : '0;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    lock_d       = lock_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d   = in_data[gnt_idx*WIDTH +: WIDTH];
        out_src_d    = gnt_idx;
        last_grant_d = gnt_idx;
`ifdef RR_MUX_REG_LOCK_EN
        lock_d       = ~in_last[gnt_idx];
`else
        lock_d       = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q   <= '0;
      out_src_q    <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= SEL_W'(NUM_IN - 1);
      lock_q       <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Randomized and directed bench for rr_mux_reg against a transaction-level model.
module tb_rr_mux_reg;
  localparam int WIDTH  = 8;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_last;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;

  int checks   = 0;
  int failures = 0;

  // Model state: the registered output word and the arbitration history.
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [SEL_W-1:0] m_src;
  int               m_last;
  logic             m_lock;

  logic [WIDTH-1:0] tbl [NUM_IN] = '{8'h10, 8'h21, 8'h32, 8'h43};

  rr_mux_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef RR_MUX_REG_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next channel in priority order that has a word, or -1.
  function automatic int pick();
    int c;
    if (m_lock) return in_valid[m_last] ? m_last : -1;
    for (int k = 1; k <= NUM_IN; k++) begin
      c = (m_last + k) % NUM_IN;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = '0;
    m_last  = NUM_IN - 1;
    m_lock  = 1'b0;
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic step();
    int g;
    logic load;
    logic [NUM_IN-1:0] exp_rdy;
    #2;
    g       = pick();
    load    = !reset && (!m_valid || out_ready);
    exp_rdy = (load && g >= 0) ? (NUM_IN'(1) << g) : '0;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*WIDTH +: WIDTH];
        m_src   = SEL_W'(g);
        m_last  = g;
`ifdef RR_MUX_REG_LOCK_EN
        m_lock  = !in_last[g];
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_src", 32'(out_src), 32'(m_src));
  endtask

  task automatic load_table();
    for (int c = 0; c < NUM_IN; c++) in_data[c*WIDTH +: WIDTH] = tbl[c];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    reset     = 1'b1;
    in_valid  = '1;
    in_last   = '1;
    out_ready = 1'b1;
    in_data   = '0;
    load_table();

    // Reset held with every channel requesting.
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_src", 32'(out_src), 32'd0);
    reset = 1'b0;

    // Fair rotation starting at channel 0.
    for (int i = 0; i < 8; i++) begin
      step();
      check("rot_src", 32'(out_src), 32'(i % NUM_IN));
      check("rot_data", 32'(out_data), 32'(tbl[i % NUM_IN]));
    end

    // Stall holding 8'h21, then resume with channel 2 in the same edge.
    do_reset();
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_data", 32'(out_data), 32'h21);
      check("stall_src", 32'(out_src), 32'd1);
    end
    out_ready = 1'b1;
    step();
    check("resume_data", 32'(out_data), 32'h32);
    check("resume_src", 32'(out_src), 32'd2);

    // Sparse requests with wrap-around, then channel 3 withdraws during a stall.
    do_reset();
    in_valid = 4'b1010;
    step();
    check("sparse_src0", 32'(out_src), 32'd1);
    step();
    check("sparse_src1", 32'(out_src), 32'd3);
    step();
    check("sparse_src2", 32'(out_src), 32'd1);
    out_ready = 1'b0;
    in_valid  = 4'b1000;
    step();
    in_valid  = 4'b0000;
    step();
    out_ready = 1'b1;
    step();
    check("drop_valid", 32'(out_valid), 32'd0);
    check("drop_src", 32'(out_src), 32'd1);

    // Single word from channel 2 then drain.
    do_reset();
    in_valid = 4'b0100;
    step();
    check("drain_v1", 32'(out_valid), 32'd1);
    check("drain_src", 32'(out_src), 32'd2);
    in_valid = 4'b0000;
    step();
    check("drain_v0", 32'(out_valid), 32'd0);
    check("drain_hold", 32'(out_data), 32'h32);

`ifdef RR_MUX_REG_LOCK_EN
    // Three-word packet on channel 0 while channel 1 waits.
    do_reset();
    in_valid = 4'b0011;
    in_last  = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) in_last[0] = 1'b1;
      in_data[0 +: WIDTH] = WIDTH'(8'hA0 + i);
      step();
      check("lock_src", 32'(out_src), 32'd0);
      check("lock_data", 32'(out_data), 32'(8'hA0 + i));
    end
    step();
    check("unlock_src", 32'(out_src), 32'd1);
`endif

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = NUM_IN'($urandom);
      in_last   = NUM_IN'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NUM_IN; c++) in_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised successor to the team's 2:1/4:1 gate-level muxes.
- Selects one of NUM_IN WIDTH-bit valid/ready input channels by round-robin arbitration rather than an external control line.
- Registers the chosen word into a single output stage.
- Sits between multiple producer units and one shared consumer.

Parameters:
- WIDTH, 8, data bits per channel
- NUM_IN, 4, number of input channels; legal range 2..16
- SEL_W, 2, width of source index; must equal ceil(log2(NUM_IN))

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_IN  channel i has a word
- in_ready  output  NUM_IN  channel i word accepted this cycle
- out_data  output  WIDTH  registered selected word
- out_src  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  out_data holds a word
- out_ready  input  1  consumer takes the word this cycle

Behaviour:
- Reset (clk edge with reset=1): out_valid=0, out_data=0, out_src=0, last_grant=NUM_IN-1.
  - Channel 0 therefore has top priority after reset.
  - Reset overrides any transfer in the same cycle.
- Priority order for arbitration: last_grant+1, last_grant+2, ... modulo NUM_IN.
  - grant is one-hot: the first requesting channel in that order.
  - grant is zero when no in_valid bit is set.
- load = ~out_valid | out_ready.
  - Combinational; out_ready-to-in_ready path is allowed.
- in_ready[i] = grant[i] & load.
  - At most one in_ready bit is high per cycle.
  - in_ready never rises for a channel with in_valid=0.
- Transfer at clk edge when load and any in_valid:
  - out_data <= selected word
  - out_src <= granted index
  - out_valid <= 1
  - last_grant <= granted index
- load with no in_valid: out_valid <= 0; out_data and out_src hold their value.
- out_valid=1 and out_ready=0:
  - Output stage stalls; out_data, out_src and last_grant hold.
  - All in_ready are 0.
- Simultaneous consume and refill: back-to-back throughput of 1 word/cycle; no bubble.
- Latency: an accepted input appears on out_data one cycle after acceptance.
- Fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,...,NUM_IN-1,0,...
- Wrap-around: a grant to index NUM_IN-1 sets the next priority to channel 0.
- in_valid dropping without acceptance is tolerated and never captured.
- Widths: out_src zero-extends the index to SEL_W; index arithmetic is modulo NUM_IN, not 2^SEL_W.
  - For non-power-of-two NUM_IN, unused index values never appear.

Optional Feature:
- Macro: RR_MUX_REG_LOCK_EN
- Defined:
  - Adds port in_last, input, NUM_IN bits, marking the final word of a packet on channel i.
  - Adds internal lock flag, reset to 0.
  - After a transfer from channel k with in_last[k]=0, lock=1 and grant is forced to k only; other channels get in_ready=0 even if valid.
  - A transfer with in_last[k]=1 clears lock; round-robin resumes from k+1.
  - While locked and in_valid[k]=0, no transfer occurs and out_valid drains to 0 when consumed.
  - Reset clears lock.
- Undefined:
  - No in_last port, no lock.
  - Every word is arbitrated independently as described above.

Test Plan:
- Reset: reset=1 with all in_valid=1 for 2 cycles -> out_valid=0, out_data=0, out_src=0, in_ready=0000. First cycle after release -> in_ready=0001; next cycle out_src=0.
- Fair rotation: NUM_IN=4, all in_valid=1, in_data = 8'h10,8'h21,8'h32,8'h43 (ch0..3), out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; out_data 10,21,32,43,...; out_valid stays 1.
- Stall: out_valid=1 holding 8'h21, out_ready=0 for 3 cycles -> out_data/out_src unchanged, in_ready=0000. out_ready=1 -> next word 8'h32 from ch2 loads in the same edge.
- Sparse/wrap: only ch3 and ch1 valid, last_grant=3 -> grant ch1, then ch3, then ch1. Ch3 drops in_valid mid-stall -> never captured.
- Drain: single word from ch2, then in_valid=0000 with out_ready=1 -> out_valid 1 for one cycle then 0; out_data holds its last value.
- Lock (RR_MUX_REG_LOCK_EN): ch0 sends 3 words with in_last=0,0,1 while ch1 is valid -> out_src 0,0,0,1; in_ready[1]=0 until the last word from ch0 is accepted.
